// File: rtl/tgl_rx_pkg.sv
// Shared types and default sizes for the toggle handshake receiver.
package tgl_rx_pkg;

  localparam int unsigned TGL_RX_DATA_W      = 8;
  localparam int unsigned TGL_RX_SYNC_STAGES = 2;
  localparam int unsigned TGL_RX_CNT_W       = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } tgl_rx_state_t;

endpackage

// File: rtl/tgl_sync.sv
// Multi-flop single-bit synchroniser with asynchronous clear.
module tgl_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_handshake_receiver.sv
// Receiver for a toggle-encoded req/ack link presenting words on a valid/ready port.
// Optional protocol error detection is built when TGL_RX_ERR_EN is defined.
module toggle_handshake_receiver
  import tgl_rx_pkg::*;
#(
  parameter int unsigned DATA_W      = TGL_RX_DATA_W,
  parameter int unsigned SYNC_STAGES = TGL_RX_SYNC_STAGES,
  parameter int unsigned CNT_W       = TGL_RX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  evt_count,
  output logic              err
);

  tgl_rx_state_t     state_q, state_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_s;
  logic              pending;

  tgl_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (req_tgl),
    .q   (req_s)
  );

  assign pending = (req_s != ack_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture on a pending request; release and acknowledge on consumer accept.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pending) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = VALID;
        end
      end
      VALID: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack_tgl   = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign evt_count = cnt_q;

`ifdef TGL_RX_ERR_EN
  logic req_s_q;
  logic err_q;

  // A req_s change while a word is held means the sender toggled again before ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_s_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      req_s_q <= req_s;
      if (state_q == VALID && req_s != req_s_q) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Randomised self-checking bench for toggle_handshake_receiver (default and CNT_W=3 instances).
module tb_toggle_handshake_receiver;

  localparam int unsigned SYNC = 2;
`ifdef TGL_RX_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_tgl;
  logic [7:0]  data_in;
  logic        out_ready;
  logic        ack_tgl, out_valid, err;
  logic [7:0]  out_data;
  logic [15:0] evt_count;
  logic        sat_ack, sat_valid, sat_err;
  logic [7:0]  sat_data;
  logic [2:0]  sat_count;

  int checks = 0;
  int passes = 0;
  int acc    = 0;
  logic [7:0] tx_words[$];

  always #5 clk = ~clk;

  toggle_handshake_receiver u_dut (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .evt_count(evt_count), .err(err)
  );

  toggle_handshake_receiver #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .req_tgl(req_tgl), .data_in(data_in),
    .ack_tgl(sat_ack), .out_valid(sat_valid), .out_data(sat_data),
    .out_ready(out_ready), .evt_count(sat_count), .err(sat_err)
  );

  function automatic logic [15:0] exp_cnt16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [2:0] exp_cnt3(input int n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_tgl = 1'b0; data_in = 8'h00; out_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    acc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ack_tgl !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack_tgl); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", out_data); else passes++;
    checks++; if (evt_count !== 16'h0) $display("FAIL reset_cnt got=%0d exp=0", evt_count); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passes++;
  endtask

  task automatic test_single();
    data_in = 8'hA5; req_tgl = 1'b1; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_early1 got=%b exp=0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL single_early2 got=%b exp=0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else passes++;
    checks++; if (out_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", out_data); else passes++;
    checks++; if (ack_tgl !== 1'b0) $display("FAIL single_ack_pre got=%b exp=0", ack_tgl); else passes++;
    step();
    acc++;
    checks++; if (ack_tgl !== 1'b1) $display("FAIL single_ack got=%b exp=1", ack_tgl); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL single_release got=%b exp=0", out_valid); else passes++;
    checks++; if (evt_count !== exp_cnt16(acc)) $display("FAIL single_cnt got=%0d exp=%0d", evt_count, exp_cnt16(acc)); else passes++;
  endtask

  task automatic test_reset_mid_transfer();
    int waited;
    out_ready = 1'b0; data_in = 8'h77; req_tgl = ~req_tgl;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    checks++; if (out_valid !== 1'b1) $display("FAIL midrst_setup got=%b exp=1", out_valid); else passes++;
    #3 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b exp=0", out_valid); else passes++;
    checks++; if (ack_tgl !== 1'b0) $display("FAIL midrst_ack got=%b exp=0", ack_tgl); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL midrst_data got=%h exp=00", out_data); else passes++;
    checks++; if (evt_count !== 16'h0) $display("FAIL midrst_cnt got=%0d exp=0", evt_count); else passes++;
    req_tgl = 1'b0;
    step(); step();
    rst = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_spurious cyc=%0d got=%b exp=0", i, out_valid); else passes++;
    end
  endtask

  task automatic test_backpressure();
    int waited;
    logic exp_ack;
    out_ready = 1'b0; data_in = 8'h3C; req_tgl = ~req_tgl;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    exp_ack = 1'(acc % 2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || ack_tgl !== exp_ack)
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h a=%b exp v=1 d=3c a=%b", i, out_valid, out_data, ack_tgl, exp_ack);
      else passes++;
      step();
    end
    out_ready = 1'b1;
    step();
    acc++;
    checks++; if (ack_tgl !== 1'(acc % 2)) $display("FAIL bp_ack got=%b exp=%b", ack_tgl, 1'(acc % 2)); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", out_valid); else passes++;
    checks++; if (evt_count !== exp_cnt16(acc)) $display("FAIL bp_cnt got=%0d exp=%0d", evt_count, exp_cnt16(acc)); else passes++;
  endtask

  // Sender/consumer traffic compared against an in-order word queue.
  task automatic run_traffic(input int n, input bit rand_ready, input bit rand_gap,
                             input bit use_words, input bit check_spacing);
    logic [7:0] exp_q[$];
    logic [7:0] d;
    int sent, cycles, last_acc;
    logic v, r;
    sent = 0; cycles = 0; last_acc = -1;
    while ((sent < n || exp_q.size() > 0) && cycles < 3000) begin
      if (sent < n && req_tgl == ack_tgl && (!rand_gap || $urandom_range(0, 2) == 0)) begin
        d = use_words ? tx_words[sent] : 8'($urandom);
        data_in = d; req_tgl = ~req_tgl; exp_q.push_back(d); sent++;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      v = out_valid; r = out_ready;
      if (v) begin
        checks++;
        if (exp_q.size() == 0) $display("FAIL traffic_spurious data=%h", out_data);
        else if (out_data !== exp_q[0]) $display("FAIL traffic_data got=%h exp=%h", out_data, exp_q[0]);
        else passes++;
      end
      step(); cycles++;
      if (v && r) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        acc++;
        checks++;
        if (ack_tgl !== 1'(acc % 2) || evt_count !== exp_cnt16(acc) || sat_count !== exp_cnt3(acc) || out_valid !== 1'b0)
          $display("FAIL traffic_accept got a=%b c=%0d s=%0d v=%b exp a=%b c=%0d s=%0d v=0",
                   ack_tgl, evt_count, sat_count, out_valid, 1'(acc % 2), exp_cnt16(acc), exp_cnt3(acc));
        else passes++;
        if (check_spacing && last_acc >= 0) begin
          checks++;
          if (cycles - last_acc != SYNC + 2) $display("FAIL traffic_spacing got=%0d exp=%0d", cycles - last_acc, SYNC + 2);
          else passes++;
        end
        last_acc = cycles;
      end else if (v) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL traffic_drop got=%b exp=1", out_valid); else passes++;
      end
    end
    checks++;
    if (sent != n || exp_q.size() != 0) $display("FAIL traffic_timeout sent=%0d exp=%0d left=%0d", sent, n, exp_q.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    tx_words = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_traffic(4, 1'b0, 1'b0, 1'b1, 1'b1);
    checks++; if (evt_count !== 16'd4) $display("FAIL b2b_cnt got=%0d exp=4", evt_count); else passes++;
    checks++; if (ack_tgl !== 1'b0) $display("FAIL b2b_ack got=%b exp=0", ack_tgl); else passes++;
  endtask

  task automatic test_saturation();
    do_reset();
    tx_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    run_traffic(9, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (sat_count !== 3'd7) $display("FAIL sat_cnt got=%0d exp=7", sat_count); else passes++;
    checks++; if (evt_count !== 16'd9) $display("FAIL sat_main_cnt got=%0d exp=9", evt_count); else passes++;
    checks++; if (sat_ack !== 1'b1) $display("FAIL sat_ack got=%b exp=1", sat_ack); else passes++;
  endtask

  task automatic test_random();
    run_traffic(40, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_error();
    int waited;
    do_reset();
    out_ready = 1'b0; data_in = 8'h5A; req_tgl = ~req_tgl;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin step(); waited++; end
    checks++; if (err !== 1'b0) $display("FAIL err_early got=%b exp=0", err); else passes++;
    req_tgl = ~req_tgl; repeat (4) step();
    req_tgl = ~req_tgl; repeat (4) step();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) $display("FAIL err_hold got v=%b d=%h exp v=1 d=5a", out_valid, out_data); else passes++;
    checks++; if (err !== EXP_ERR) $display("FAIL err_set got=%b exp=%b", err, EXP_ERR); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || ack_tgl !== 1'b1) $display("FAIL err_accept got v=%b a=%b exp v=0 a=1", out_valid, ack_tgl); else passes++;
    repeat (8) step();
    checks++; if (err !== EXP_ERR) $display("FAIL err_sticky got=%b exp=%b", err, EXP_ERR); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL err_extra_word got=%b exp=0", out_valid); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid_transfer();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_random();
    test_error();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
